// File: rtl/counter_monitor_pkg.sv
// Shared types for counter_monitor: FSM states, mode encodings, transition
// classes and the even/odd successor tables of the observed 3-bit counter.
package counter_monitor_pkg;

  typedef enum logic [1:0] {
    ST_ACQ   = 2'b00,
    ST_EVEN  = 2'b01,
    ST_ODD   = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  localparam logic [1:0] MODE_UNKNOWN = 2'b00;
  localparam logic [1:0] MODE_EVEN    = 2'b01;
  localparam logic [1:0] MODE_ODD     = 2'b10;
  localparam logic [1:0] MODE_FAULT   = 2'b11;

  typedef enum logic [2:0] {
    CLS_EVEN_STEP  = 3'd0,
    CLS_ODD_STEP   = 3'd1,
    CLS_ENTER_EVEN = 3'd2,
    CLS_ENTER_ODD  = 3'd3,
    CLS_ZERO       = 3'd4,
    CLS_ILLEGAL    = 3'd5
  } cls_t;

  // Only meaningful for an even argument.
  function automatic logic [2:0] even_succ(input logic [2:0] v);
    case (v)
      3'd0:    return 3'd2;
      3'd2:    return 3'd4;
      3'd4:    return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  // Only meaningful for an odd argument.
  function automatic logic [2:0] odd_succ(input logic [2:0] v);
    case (v)
      3'd7:    return 3'd5;
      3'd5:    return 3'd3;
      3'd3:    return 3'd1;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/counter_seq_classify.sv
// Classifies one observed counter transition (prev_q -> q_in).
// Purely combinational, no state, no backpressure.
module counter_seq_classify
  import counter_monitor_pkg::*;
(
  input  logic [2:0] prev_q,
  input  logic [2:0] q_in,
  output cls_t       cls
);

  logic prev_odd;

  assign prev_odd = prev_q[0];

  // Step/enter classes take precedence over ZERO, so 6->0 is a wrap and 7->0 an entry.
  always_comb begin
    cls = CLS_ILLEGAL;
    if (!prev_odd && q_in == even_succ(prev_q)) begin
      cls = CLS_EVEN_STEP;
    end else if (prev_odd && q_in == odd_succ(prev_q)) begin
      cls = CLS_ODD_STEP;
    end else if (prev_odd && q_in == prev_q + 3'd1) begin
      cls = CLS_ENTER_EVEN;
    end else if (!prev_odd && q_in == prev_q - 3'd1) begin
      cls = CLS_ENTER_ODD;
    end else if (q_in == 3'd0 && prev_q != 3'd6 && prev_q != 3'd1) begin
      cls = CLS_ZERO;
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// Watches a 3-bit even/odd counter, decodes direction, flags errors/wraps; pulses one cycle after the sample.
// No backpressure; COUNTER_MONITOR_LAPCNT_EN enables the saturating lap counter (otherwise lap_cnt = 0).
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int ERR_THRESH = 3,
  parameter int LAP_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       q_in,
  input  logic             clr,
  output logic [1:0]       mode,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic             fault,
  output logic [LAP_W-1:0] lap_cnt
);

  localparam logic [3:0] THRESH = 4'(ERR_THRESH);

  state_t     state_q, state_d;
  logic [2:0] prev_q;
  logic       prev_vld;
  logic [3:0] err_run, err_run_d, err_run_inc;
  cls_t       cls;
  logic       is_illegal;
  logic       is_wrap;

  counter_seq_classify u_classify (
    .prev_q (prev_q),
    .q_in   (q_in),
    .cls    (cls)
  );

  assign is_illegal  = prev_vld && (cls == CLS_ILLEGAL);
  assign is_wrap     = prev_vld && (state_q != ST_FAULT) &&
                       (((cls == CLS_EVEN_STEP) && (prev_q == 3'd6)) ||
                        ((cls == CLS_ODD_STEP)  && (prev_q == 3'd1)));
  assign err_run_inc = (err_run == 4'hF) ? 4'hF : err_run + 4'd1;

  always_comb begin
    state_d   = state_q;
    err_run_d = err_run;
    if (clr) begin
      state_d   = ST_ACQ;
      err_run_d = 4'd0;
    end else if (prev_vld) begin
      if (cls == CLS_ILLEGAL) begin
        err_run_d = err_run_inc;
        if (err_run_inc >= THRESH) state_d = ST_FAULT;
      end else begin
        err_run_d = 4'd0;
        // Any legal class steers direction; FAULT is sticky until clr/rst.
        if (state_q != ST_FAULT) begin
          case (cls)
            CLS_EVEN_STEP, CLS_ENTER_EVEN: state_d = ST_EVEN;
            CLS_ODD_STEP,  CLS_ENTER_ODD:  state_d = ST_ODD;
            CLS_ZERO:                      state_d = ST_ACQ;
            default:                       state_d = state_q;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ACQ;
      err_run    <= 4'd0;
      prev_q     <= 3'd0;
      prev_vld   <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_run    <= err_run_d;
      err_pulse  <= !clr && is_illegal;
      wrap_pulse <= !clr && is_wrap;
      if (clr) begin
        prev_vld <= 1'b0;
      end else begin
        prev_vld <= 1'b1;
        prev_q   <= q_in;
      end
    end
  end

  assign mode  = state_q;
  assign fault = (state_q == ST_FAULT);

`ifdef COUNTER_MONITOR_LAPCNT_EN
  logic [LAP_W-1:0] lap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_q <= '0;
    end else if (!clr && is_wrap && (lap_q != '1)) begin
      lap_q <= lap_q + 1'b1;
    end
  end

  assign lap_cnt = lap_q;
`else
  assign lap_cnt = '0;
`endif

endmodule

// File: tb/tb_counter_monitor.sv
// Self-checking bench for counter_monitor against a transition-rule reference model.
module tb_counter_monitor;

  localparam int ERR_THRESH = 3;
  localparam int LAP_W      = 8;
`ifdef COUNTER_MONITOR_LAPCNT_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif
  localparam int LAP_MAX = (1 << LAP_W) - 1;
  localparam int C_ES = 0, C_OS = 1, C_EE = 2, C_EO = 3, C_ZERO = 4, C_ILL = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clr = 1'b0;
  logic [2:0]       q_in = 3'd0;
  logic [1:0]       mode;
  logic             err_pulse, wrap_pulse, fault;
  logic [LAP_W-1:0] lap_cnt;
  logic [LAP_W+4:0] obs;

  int errors = 0;
  int checks = 0;

  bit m_vld, m_err, m_wrap;
  int m_prev, m_mode, m_run, m_lap;

  counter_monitor #(.ERR_THRESH(ERR_THRESH), .LAP_W(LAP_W)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .clr(clr), .mode(mode),
    .err_pulse(err_pulse), .wrap_pulse(wrap_pulse), .fault(fault), .lap_cnt(lap_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {mode, err_pulse, wrap_pulse, fault, lap_cnt};

  function automatic int classify(int p, int q);
    if (p % 2 == 0 && q == (p + 2) % 8) return C_ES;
    if (p % 2 == 1 && q == (p + 6) % 8) return C_OS;
    if (p % 2 == 1 && q == (p + 1) % 8) return C_EE;
    if (p % 2 == 0 && q == (p + 7) % 8) return C_EO;
    if (q == 0 && p != 6 && p != 1) return C_ZERO;
    return C_ILL;
  endfunction

  function automatic logic [LAP_W+4:0] exp_vec();
    return {2'(m_mode), m_err, m_wrap, (m_mode == 3), LAP_W'(m_lap)};
  endfunction

  task automatic model_reset();
    m_vld = 0; m_err = 0; m_wrap = 0;
    m_prev = 0; m_mode = 0; m_run = 0; m_lap = 0;
  endtask

  task automatic model_update(input int q, input bit c);
    int k;
    if (c) begin
      m_mode = 0; m_vld = 0; m_run = 0; m_err = 0; m_wrap = 0;
    end else if (!m_vld) begin
      m_vld = 1; m_prev = q; m_err = 0; m_wrap = 0;
    end else begin
      k      = classify(m_prev, q);
      m_err  = (k == C_ILL);
      m_wrap = (m_mode != 3) && ((k == C_ES && m_prev == 6) || (k == C_OS && m_prev == 1));
      if (m_wrap && LAP_EN && m_lap < LAP_MAX) m_lap++;
      if (k == C_ILL) begin
        if (m_run < 15) m_run++;
        if (m_run >= ERR_THRESH) m_mode = 3;
      end else begin
        m_run = 0;
        if (m_mode != 3) begin
          if (k == C_ES || k == C_EE) m_mode = 1;
          else if (k == C_OS || k == C_EO) m_mode = 2;
          else m_mode = 0;
        end
      end
      m_prev = q;
    end
  endtask

  // Drives one sample on the falling edge; returns 1 time unit after the rising edge.
  task automatic step(input int q, input bit c);
    @(negedge clk);
    q_in = 3'(q);
    clr  = c;
    @(posedge clk);
    model_update(q, c);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #7;
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_state: got %b expected %b", obs, {(LAP_W+5){1'b0}});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_even();
    int seq[6] = '{0, 2, 4, 6, 0, 2};
    int wraps = 0;
    for (int i = 0; i < 6; i++) begin
      step(seq[i], 0);
      wraps += int'(wrap_pulse);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL even_seq[%0d]: got %b expected %b", i, obs, exp_vec());
      end
      if (i == 2) begin
        checks++;
        if (mode !== 2'b01) begin
          errors++; $display("FAIL even_mode_third: got %b expected 01", mode);
        end
      end
    end
    checks++;
    if (wraps != 1) begin
      errors++; $display("FAIL even_wrap_count: got %0d expected 1", wraps);
    end
    checks++;
    if (lap_cnt !== LAP_W'(LAP_EN ? 1 : 0)) begin
      errors++; $display("FAIL even_lap: got %0d expected %0d", lap_cnt, LAP_EN ? 1 : 0);
    end
  endtask

  task automatic test_odd();
    int seq[5] = '{7, 5, 3, 1, 7};
    int wraps = 0, errs = 0;
    step(0, 1);
    for (int i = 0; i < 5; i++) begin
      step(seq[i], 0);
      wraps += int'(wrap_pulse);
      errs  += int'(err_pulse);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL odd_seq[%0d]: got %b expected %b", i, obs, exp_vec());
      end
    end
    checks++;
    if (mode !== 2'b10 || wraps != 1 || errs != 0) begin
      errors++; $display("FAIL odd_summary: got mode=%b wraps=%0d errs=%0d expected mode=10 wraps=1 errs=0",
                         mode, wraps, errs);
    end
  endtask

  task automatic test_switch();
    int seq[5] = '{2, 4, 3, 1, 7};
    int errs = 0;
    bit saw_even = 0, saw_odd_after = 0;
    step(0, 1);
    for (int i = 0; i < 5; i++) begin
      step(seq[i], 0);
      errs += int'(err_pulse);
      if (mode == 2'b01) saw_even = 1;
      if (mode == 2'b10 && saw_even) saw_odd_after = 1;
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL switch_seq[%0d]: got %b expected %b", i, obs, exp_vec());
      end
    end
    checks++;
    if (!saw_even || !saw_odd_after || errs != 0) begin
      errors++; $display("FAIL switch_summary: got even=%0d odd_after=%0d errs=%0d expected 1 1 0",
                         saw_even, saw_odd_after, errs);
    end
  endtask

  task automatic test_fault();
    int seq[5] = '{0, 2, 5, 7, 1};
    int errs = 0;
    step(0, 1);
    for (int i = 0; i < 5; i++) begin
      step(seq[i], 0);
      errs += int'(err_pulse);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL fault_seq[%0d]: got %b expected %b", i, obs, exp_vec());
      end
    end
    checks++;
    if (errs != 3 || fault !== 1'b1 || mode !== 2'b11) begin
      errors++; $display("FAIL fault_entry: got errs=%0d fault=%b mode=%b expected 3 1 11", errs, fault, mode);
    end
    step(3, 1);
    checks++;
    if (mode !== 2'b00 || fault !== 1'b0 || lap_cnt !== LAP_W'(LAP_EN ? 3 : 0)) begin
      errors++; $display("FAIL fault_clr: got mode=%b fault=%b lap=%0d expected 00 0 %0d",
                         mode, fault, lap_cnt, LAP_EN ? 3 : 0);
    end
  endtask

  task automatic test_zero_and_clr();
    int qs[4] = '{4, 0, 3, 6};
    bit cs[4] = '{0, 0, 0, 1};
    bit want_err[4] = '{0, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      step(qs[i], cs[i]);
      checks++;
      if (obs !== exp_vec() || err_pulse !== want_err[i]) begin
        errors++; $display("FAIL zero_clr[%0d]: got %b expected %b (err %b)", i, obs, exp_vec(), want_err[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    int seq[5] = '{0, 2, 4, 6, 0};
    for (int i = 0; i < 5; i++) step(seq[i], 0);
    checks++;
    if (obs !== exp_vec() || wrap_pulse !== 1'b1) begin
      errors++; $display("FAIL async_pre: got %b expected %b", obs, exp_vec());
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL async_reset: got %b expected all zero", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(3, 0);
    step(5, 0);
    checks++;
    if (obs !== exp_vec() || err_pulse !== 1'b1) begin
      errors++; $display("FAIL async_reload: got %b expected %b", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    int q;
    bit c;
    step(0, 1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        if (m_prev % 2 == 0) q = ($urandom_range(0, 1) == 1) ? (m_prev + 2) % 8 : (m_prev + 7) % 8;
        else                 q = ($urandom_range(0, 1) == 1) ? (m_prev + 6) % 8 : (m_prev + 1) % 8;
      end else begin
        q = int'($urandom_range(0, 7));
      end
      c = ($urandom_range(0, 15) == 0);
      step(q, c);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random[%0d]: q=%0d clr=%0d got %b expected %b", i, q, c, obs, exp_vec());
      end
    end
  endtask

  task automatic test_lap_saturate();
    int wraps = 0;
    step(0, 1);
    for (int i = 0; i < 265 * 4; i++) begin
      step((i % 4) * 2, 0);
      wraps += int'(wrap_pulse);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL lap_sat[%0d]: got %b expected %b", i, obs, exp_vec());
      end
    end
    checks++;
    if (wraps != 264 || lap_cnt !== LAP_W'(LAP_EN ? LAP_MAX : 0)) begin
      errors++; $display("FAIL lap_sat_final: got wraps=%0d lap=%0d expected 264 %0d",
                         wraps, lap_cnt, LAP_EN ? LAP_MAX : 0);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_even();
    test_odd();
    test_switch();
    test_fault();
    test_zero_and_clr();
    test_async_reset();
    test_random();
    test_lap_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
